pattern_pulse_gen: RTL and testbench



---
 rtl/pattern_pulse_gen_pkg.sv | 21 ++
 rtl/pattern_pulse_gen_hold_ticker.sv | 45 ++++
 rtl/pattern_pulse_gen.sv | 144 ++++++++++++++
 tb/tb_pattern_pulse_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pattern_pulse_gen_pkg.sv
// pattern_pulse_gen_pkg
//   Shared types and helpers for the serial pattern generator.
//   state_t  : playback FSM state (IDLE, RUN)
//   norm_len : maps an out-of-range bit length (0 or > width) to the full width
package pattern_pulse_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A length of 0 or anything wider than the pattern register plays the
    // whole register.
    function automatic int unsigned norm_len(input int unsigned len_in,
                                             input int unsigned width);
        if (len_in == 0 || len_in > width)
            return width;
        return len_in;
    endfunction

endpackage

// File: rtl/pattern_pulse_gen_hold_ticker.sv
// hold_ticker
//   Down-counter that sets how long each pattern bit is held on the output.
//   tick is high in the last cycle of a bit, i.e. in the cycle whose closing
//   edge advances the bit index; each bit therefore lasts reload_val+1 cycles.
//   Ports:
//     clock, reset_n : clock, async active-low reset
//     start          : load start_val (new playback begins)
//     start_val      : hold value captured together with start
//     clear          : force the counter to 0 (playback aborted)
//     en             : count while playing
//     reload_val     : hold value used on every subsequent bit
//     tick           : one-cycle advance strobe
module hold_ticker #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DIV_W-1:0] start_val,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    // Counting down to 0 and reloading means hold = 2^DIV_W-1 never wraps
    // incorrectly: the counter simply starts at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (start)
            cnt <= start_val;
        else if (clear)
            cnt <= '0;
        else if (tick)
            cnt <= reload_val;
        else if (en)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/pattern_pulse_gen.sv
// pattern_pulse_gen
//   Serial pattern player: captures a WIDTH-bit pattern plus length, hold,
//   bit order and repeat mode on load, then shifts it out one bit at a time.
//   Ports:
//     clock, reset_n : clock, async active-low reset
//     pattern        : pattern to play (captured on load)
//     len            : bits to play, 0 or >WIDTH means WIDTH
//     hold           : each bit lasts hold+1 cycles
//     load           : capture config and (re)start playback; beats stop
//     stop           : abort playback without a done pulse
//     repeat_mode    : 1 = loop passes back to back, 0 = one pass
//     msb_first      : 1 = pattern[len-1] first, 0 = pattern[0] first
//     out            : registered serial output, 0 when idle
//     busy           : high while playing
//     done           : one-cycle pulse after the last bit of each pass
module pattern_pulse_gen
    import pattern_pulse_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] hold,
    input  logic             load,
    input  logic             stop,
    input  logic             repeat_mode,
    input  logic             msb_first,
    output logic             out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] pat_s;
    logic [LEN_W-1:0] len_s;
    logic [DIV_W-1:0] hold_s;
    logic             rep_s;
    logic             msb_s;
    logic [LEN_W-1:0] count, count_n;
    logic             out_n, done_n;
    logic [LEN_W-1:0] len_in_norm;
    logic             tick;

    // Bit k of the playback order for a given pattern/length/direction.
    // A shift is used instead of a variable part-select so the index width
    // need not match the pattern width.
    function automatic logic bit_at(input logic [WIDTH-1:0] p,
                                    input logic [LEN_W-1:0] l,
                                    input logic [LEN_W-1:0] k,
                                    input logic             m);
        logic [LEN_W-1:0] idx;
        logic [WIDTH-1:0] sh;
        idx = m ? (l - k - 1'b1) : k;
        sh  = p >> idx;
        return sh[0];
    endfunction

    assign len_in_norm = LEN_W'(norm_len(32'(len), 32'(WIDTH)));

    hold_ticker #(.DIV_W(DIV_W)) u_ticker (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (load),
        .start_val  (hold),
        .clear      (stop && !load),
        .en         (state == RUN),
        .reload_val (hold_s),
        .tick       (tick)
    );

    // Shadow config: only load changes it, so mid-playback input changes
    // have no effect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_s  <= '0;
            len_s  <= '0;
            hold_s <= '0;
            rep_s  <= 1'b0;
            msb_s  <= 1'b0;
        end else if (load) begin
            pat_s  <= pattern;
            len_s  <= len_in_norm;
            hold_s <= hold;
            rep_s  <= repeat_mode;
            msb_s  <= msb_first;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            out   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            out   <= out_n;
            done  <= done_n;
        end
    end

    // out is computed one cycle ahead so that it is a plain register and
    // lines up with busy/done.
    always_comb begin
        state_n = state;
        count_n = count;
        out_n   = out;
        done_n  = 1'b0;
        if (load) begin
            state_n = RUN;
            count_n = '0;
            out_n   = bit_at(pattern, len_in_norm, '0, msb_first);
        end else if (state == RUN) begin
            if (stop) begin
                state_n = IDLE;
                count_n = '0;
                out_n   = 1'b0;
            end else if (tick) begin
                if (count == len_s - 1'b1) begin
                    done_n  = 1'b1;
                    count_n = '0;
                    if (rep_s) begin
                        // Wrap straight to the first bit: no gap cycle.
                        out_n = bit_at(pat_s, len_s, '0, msb_s);
                    end else begin
                        state_n = IDLE;
                        out_n   = 1'b0;
                    end
                end else begin
                    count_n = count + 1'b1;
                    out_n   = bit_at(pat_s, len_s, count + 1'b1, msb_s);
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_pattern_pulse_gen.sv
module tb_pattern_pulse_gen;

    logic        clock;
    logic        reset_n;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [7:0]  hold;
    logic        load;
    logic        stop;
    logic        repeat_mode;
    logic        msb_first;
    logic        out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // 16'h5254 MSB-first over 16 bits
    logic exp_msb [16] = '{0,1,0,1, 0,0,1,0, 0,1,0,1, 0,1,0,0};
    // 16'h000B LSB-first, len 4, hold 2
    logic exp_lsb [12] = '{1,1,1, 1,1,1, 0,0,0, 1,1,1};
    // 16'h0006 MSB-first, len 3, repeating
    logic exp_rep [9]  = '{1,1,0, 1,1,0, 1,1,0};

    pattern_pulse_gen #(.WIDTH(16), .DIV_W(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pattern     (pattern),
        .len         (len),
        .hold        (hold),
        .load        (load),
        .stop        (stop),
        .repeat_mode (repeat_mode),
        .msb_first   (msb_first),
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic eo, input logic eb, input logic ed);
        chk({tag, ".out"},  out,  eo);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".done"}, done, ed);
    endtask

    initial begin
        reset_n = 1'b0; pattern = '0; len = '0; hold = '0;
        load = 1'b0; stop = 1'b0; repeat_mode = 1'b0; msb_first = 1'b0;
        #3;
        chk3("reset", 1'b0, 1'b0, 1'b0);
        #9 reset_n = 1'b1;
        step();
        chk3("idle_after_reset", 1'b0, 1'b0, 1'b0);

        // One-shot MSB-first, full length
        pattern = 16'h5254; len = 5'd16; hold = 8'd0; msb_first = 1'b1;
        repeat_mode = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk3($sformatf("msb_bit%0d", i), exp_msb[i], 1'b1, 1'b0);
            step();
        end
        chk3("msb_done", 1'b0, 1'b0, 1'b1);
        step();
        chk3("msb_idle", 1'b0, 1'b0, 1'b0);

        // LSB-first, len 4, hold 2
        pattern = 16'h000B; len = 5'd4; hold = 8'd2; msb_first = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk3($sformatf("lsb_cyc%0d", i), exp_lsb[i], 1'b1, 1'b0);
            step();
        end
        chk3("lsb_done", 1'b0, 1'b0, 1'b1);
        step();
        chk3("lsb_idle", 1'b0, 1'b0, 1'b0);

        // Repeat mode, config changed mid-run without load, then stop
        pattern = 16'h0006; len = 5'd3; hold = 8'd0; msb_first = 1'b1;
        repeat_mode = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk3($sformatf("rep_cyc%0d", i), exp_rep[i], 1'b1,
                 (i == 3 || i == 6) ? 1'b1 : 1'b0);
            if (i == 4) begin
                pattern = 16'hFFFF; len = 5'd0; msb_first = 1'b0; repeat_mode = 1'b0;
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk3("stop", 1'b0, 1'b0, 1'b0);
        step();
        chk3("stop_idle", 1'b0, 1'b0, 1'b0);

        // stop + load together: load wins; new config len=0 -> 16 bits LSB-first
        pattern = 16'h0006; len = 5'd3; msb_first = 1'b1; repeat_mode = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        chk3("sl_pre0", 1'b1, 1'b1, 1'b0);
        step();
        chk3("sl_pre1", 1'b1, 1'b1, 1'b0);
        pattern = 16'h0001; len = 5'd0; hold = 8'd0; msb_first = 1'b0;
        repeat_mode = 1'b0; load = 1'b1; stop = 1'b1;
        step();
        load = 1'b0; stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk3($sformatf("len0_bit%0d", i), (i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            step();
        end
        chk3("len0_done", 1'b0, 1'b0, 1'b1);
        step();

        // Maximum hold: two bits, 256 cycles each
        pattern = 16'h0002; len = 5'd2; hold = 8'd255; msb_first = 1'b1;
        repeat_mode = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("hmax_cyc%0d.out", i), out, (i < 256) ? 1'b1 : 1'b0);
            chk($sformatf("hmax_cyc%0d.done", i), done, 1'b0);
            step();
        end
        chk3("hmax_done", 1'b0, 1'b0, 1'b1);
        step();

        // Asynchronous reset mid-run
        pattern = 16'hFFFF; len = 5'd16; hold = 8'd3; repeat_mode = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk3("pre_reset", 1'b1, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk3("async_reset", 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        step();
        chk3("post_reset0", 1'b0, 1'b0, 1'b0);
        step();
        chk3("post_reset1", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
